// File: rtl/lpddr_pkg.sv
// rtl/lpddr_pkg.sv - shared types for the LPDDR APB register-port arbiter
// Purpose: FSM state encoding and size limits used by lpddr_apb_arb and its sub-modules.
// Ports: none (package).
package lpddr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_arb_state_e;

    localparam int ARB_N_REQ_MAX = 8;

endpackage

// File: rtl/lpddr_rr_arbiter.sv
// rtl/lpddr_rr_arbiter.sv - combinational round-robin pick
// Purpose: selects the first requester at or after i_ptr (wrapping modulo N_REQ).
// Ports:
//   i_req   in  N_REQ   request vector
//   i_ptr   in  IDX_W   highest-priority index
//   o_grant out N_REQ   one-hot grant (zero when no request)
//   o_idx   out IDX_W   binary index of the grant
//   o_any   out 1       at least one request present
module lpddr_rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [2*N_REQ-1:0] w_req2;
    logic [N_REQ-1:0]   w_rot;
    logic [IDX_W:0]     w_sum;

    // Doubling the vector lets a plain part-select perform the rotation.
    assign w_req2 = {i_req, i_req};
    assign w_rot  = w_req2[i_ptr +: N_REQ];
    assign o_any  = |i_req;

    always_comb begin
        w_sum   = '0;
        o_grant = '0;
        // Scan from the top so the lowest rotated position wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
            end
        end
        if (w_sum >= (IDX_W+1)'(N_REQ)) begin
            w_sum = w_sum - (IDX_W+1)'(N_REQ);
        end
        o_idx          = w_sum[IDX_W-1:0];
        o_grant[o_idx] = o_any;
    end

endmodule

// File: rtl/lpddr_apb_arb.sv
// rtl/lpddr_apb_arb.sv - round-robin arbiter sharing one APB master port among N_REQ requesters
// Purpose: accepts one command per requester (valid/ready), runs a SETUP/ACCESS APB transfer,
//   and returns a one-hot completion pulse with shared read data.
// Optional feature macro: LPDDR_APB_ARB_TIMEOUT_EN (ACCESS aborts after TIMEOUT_CYC cycles without pready).
// Ports:
//   pclk, preset                  clock, synchronous active-high reset
//   req_valid/req_write           per-requester command valid and direction (1=write)
//   req_addr/req_wdata            packed per-requester address / write data
//   req_ready                     one-hot accept pulse
//   rsp_valid/rsp_rdata/rsp_err   one-hot completion, last read data, timeout flag
//   paddr/pwdata/pwrite/psel/penable, pready/prdata   APB master interface
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif
module lpddr_apb_arb
    import lpddr_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = `APB_ADDR_WIDTH,
    parameter int DATA_W = `APB_DATA_WIDTH
`ifdef LPDDR_APB_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 16
`endif
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_write,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_wdata,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic [ADDR_W-1:0]        paddr,
    output logic [DATA_W-1:0]        pwdata,
    output logic                     pwrite,
    output logic                     psel,
    output logic                     penable,
    input  logic                     pready,
    input  logic [DATA_W-1:0]        prdata
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    apb_arb_state_e    r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_ptr, w_idx;
    logic [N_REQ-1:0]  w_grant, r_gnt, r_rsp_valid;
    logic              w_any, w_accept, w_done, w_abort;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata;
    logic              r_write;

    lpddr_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_accept = (r_state == IDLE) && w_any;
    assign w_done   = (r_state == ACCESS) && pready;

`ifdef LPDDR_APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // r_cnt holds the number of ACCESS cycles already spent, so the abort
    // fires at the end of the TIMEOUT_CYC-th one.
    assign w_abort = (r_state == ACCESS) && !pready && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign rsp_err = r_err;

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= (r_state == ACCESS) ? r_cnt + CNT_W'(1) : '0;
            r_err <= w_abort;
        end
    end
`else
    assign w_abort = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        psel        = 1'b0;
        penable     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    req_ready   = w_grant;
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                psel        = 1'b1;
                w_state_nxt = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready || w_abort) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_write     <= 1'b0;
            r_rsp_valid <= '0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= '0;
            if (w_accept) begin
                r_gnt   <= w_grant;
                r_addr  <= req_addr[w_idx*ADDR_W +: ADDR_W];
                r_wdata <= req_wdata[w_idx*DATA_W +: DATA_W];
                r_write <= req_write[w_idx];
                r_ptr   <= (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
            end
            if (w_done) begin
                r_rsp_valid <= r_gnt;
                if (!r_write) begin
                    r_rdata <= prdata;
                end
            end else if (w_abort) begin
                r_rsp_valid <= r_gnt;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign paddr     = r_addr;
    assign pwdata    = r_wdata;
    assign pwrite    = r_write;

endmodule

// File: tb/tb_lpddr_apb_arb.sv
// tb/tb_lpddr_apb_arb.sv - self-checking bench for lpddr_apb_arb
module tb_lpddr_apb_arb;

    localparam int NR = 3;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TO = 16;

    logic             pclk, preset;
    logic [NR-1:0]    req_valid, req_write, req_ready, rsp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [DW-1:0]    rsp_rdata, pwdata, prdata;
    logic [AW-1:0]    paddr;
    logic             rsp_err, pwrite, psel, penable, pready;

    lpddr_apb_arb #(
        .N_REQ(NR), .ADDR_W(AW), .DATA_W(DW)
`ifdef LPDDR_APB_ARB_TIMEOUT_EN
        , .TIMEOUT_CYC(TO)
`endif
    ) dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
        .pready(pready), .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    // APB slave register bank
    logic [DW-1:0] mem [0:255];
    assign prdata = mem[paddr];
    always @(posedge pclk) begin
        if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // requester stimulus
    bit            pend [NR];
    bit            pw   [NR];
    logic [AW-1:0] pa   [NR];
    logic [DW-1:0] pd   [NR];
    bit            pready_rand;

    // reference model: transaction-level view of the shared port
    logic [DW-1:0] ref_mem [0:255];
    int            cyc, m_ptr, setup_cyc, rsp_cyc, rsp_own, acc_n;
    bit            busy, rsp_err_e, seen_err;
    int            own;
    bit            own_w;
    logic [AW-1:0] own_a;
    logic [DW-1:0] own_d, exp_rdata;
    int            glog[$];

    task automatic complete(input bit err);
        rsp_cyc   = cyc + 1;
        rsp_own   = own;
        rsp_err_e = err;
        if (!err) begin
            if (own_w) ref_mem[own_a] = own_d;
            else       exp_rdata = ref_mem[own_a];
        end
        busy = 0;
    endtask

    task automatic tick();
        logic [NR-1:0] exp_rdy, exp_rv;
        int g, j;
        for (int i = 0; i < NR; i++) begin
            req_valid[i]           = pend[i];
            req_write[i]           = pw[i];
            req_addr[i*AW +: AW]   = pa[i];
            req_wdata[i*DW +: DW]  = pd[i];
        end
        if (pready_rand) pready = ($urandom_range(0, 3) != 0);
        @(negedge pclk);
        g = -1;
        exp_rdy = '0;
        if (!busy) begin
            for (int k = 0; k < NR; k++) begin
                j = (m_ptr + k) % NR;
                if (g < 0 && pend[j]) g = j;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        for (int k = 0; k < NR; k++) if (req_ready[k]) glog.push_back(k);
        exp_rv = '0;
        if (cyc == rsp_cyc) exp_rv[rsp_own] = 1'b1;
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        chk("rsp_err", 32'(rsp_err), 32'((cyc == rsp_cyc) && rsp_err_e));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
        chk("psel", 32'(psel), 32'(busy));
        chk("penable", 32'(penable), 32'(busy && cyc > setup_cyc));
        if (rsp_valid != 0 && rsp_err) seen_err = 1;
        if (busy) begin
            chk("paddr", 32'(paddr), 32'(own_a));
            chk("pwrite", 32'(pwrite), 32'(own_w));
            if (own_w) chk("pwdata", 32'(pwdata), 32'(own_d));
            if (cyc > setup_cyc) begin
                acc_n++;
                if (pready) complete(1'b0);
`ifdef LPDDR_APB_ARB_TIMEOUT_EN
                else if (acc_n == TO) complete(1'b1);
`endif
            end
        end
        if (g >= 0) begin
            busy      = 1;
            own       = g;
            own_w     = pw[g];
            own_a     = pa[g];
            own_d     = pd[g];
            setup_cyc = cyc + 1;
            acc_n     = 0;
            pend[g]   = 0;
            m_ptr     = (g + 1) % NR;
        end
        @(posedge pclk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        for (int i = 0; i < NR; i++) pend[i] = 0;
        req_valid = '0;
        pready    = 1'b0;
        preset    = 1'b1;
        @(posedge pclk);
        #1;
        preset    = 1'b0;
        busy      = 0;
        m_ptr     = 0;
        rsp_cyc   = -1;
        exp_rdata = '0;
        cyc++;
    endtask

    task automatic post(input int r, input bit w, input int a, input int d);
        pend[r] = 1;
        pw[r]   = w;
        pa[r]   = AW'(a);
        pd[r]   = DW'(d);
    endtask

    initial begin
        pclk = 0;
        preset = 1;
        pready = 1;
        pready_rand = 0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < NR; i++) begin pend[i] = 0; pw[i] = 0; pa[i] = '0; pd[i] = '0; end
        for (int a = 0; a < 256; a++) begin
            mem[a] = DW'(a * 3 + 1);
            ref_mem[a] = DW'(a * 3 + 1);
        end
        mem[3] = 16'h00A5;
        ref_mem[3] = 16'h00A5;
        cyc = 0; m_ptr = 0; busy = 0; rsp_cyc = -1; exp_rdata = '0; seen_err = 0; acc_n = 0;
        repeat (2) @(posedge pclk);
        #1;
        preset = 0;

        // reset values
        @(negedge pclk);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_psel", 32'(psel), 0);
        chk("rst_penable", 32'(penable), 0);
        chk("rst_pwrite", 32'(pwrite), 0);
        chk("rst_paddr", 32'(paddr), 0);
        chk("rst_pwdata", 32'(pwdata), 0);
        @(posedge pclk);
        #1;
        cyc++;

        // single read, 3-cycle accept-to-response latency
        pready = 1;
        post(0, 0, 3, 0);
        repeat (5) tick();
        chk("t1_rdata", 32'(rsp_rdata), 32'h00A5);

        // write then read the same register
        post(1, 1, 5, 16'h1234);
        repeat (4) tick();
        post(1, 0, 5, 0);
        repeat (5) tick();
        chk("t2_rdata", 32'(rsp_rdata), 32'h1234);

        // contention between req0 and req1
        do_reset();
        glog.delete();
        pready = 1;
        for (int t = 0; t < 12; t++) begin
            if (!pend[0]) post(0, 0, $urandom_range(0, 7), 0);
            if (!pend[1]) post(1, 0, $urandom_range(0, 7), 0);
            tick();
        end
        pend[0] = 0; pend[1] = 0;
        repeat (4) tick();
        chk("t3_ngrants", 32'(glog.size() >= 4), 1);
        if (glog.size() >= 4) begin
            chk("t3_g0", 32'(glog[0]), 0);
            chk("t3_g1", 32'(glog[1]), 1);
            chk("t3_g2", 32'(glog[2]), 0);
            chk("t3_g3", 32'(glog[3]), 1);
        end

        // pointer wrap after grant 2
        do_reset();
        pready = 1;
        for (int r = 0; r < NR; r++) begin
            post(r, 0, r + 10, 0);
            repeat (3) tick();
        end
        glog.delete();
        post(0, 0, 20, 0);
        post(2, 0, 21, 0);
        repeat (8) tick();
        chk("t4_ngrants", 32'(glog.size()), 2);
        if (glog.size() >= 1) chk("t4_wrap_grant", 32'(glog[0]), 0);

        // reset while in ACCESS
        do_reset();
        post(1, 0, 7, 0);
        post(2, 0, 8, 0);
        tick();
        pend[2] = 0;
        repeat (2) tick();
        do_reset();
        tick();
        chk("t5_psel", 32'(psel), 0);
        glog.delete();
        pready = 1;
        post(0, 0, 9, 0);
        post(1, 0, 9, 0);
        tick();
        chk("t5_ngrants", 32'(glog.size()), 1);
        if (glog.size() >= 1) chk("t5_grant_req0", 32'(glog[0]), 0);
        repeat (6) tick();

        // pready held low
        pready = 0;
        seen_err = 0;
        post(0, 0, 2, 0);
        repeat (24) tick();
`ifdef LPDDR_APB_ARB_TIMEOUT_EN
        chk("t6_timeout_err", 32'(seen_err), 1);
`else
        chk("t6_psel_hold", 32'(psel), 1);
        chk("t6_penable_hold", 32'(penable), 1);
`endif
        pready = 1;
        repeat (4) tick();

        // randomized traffic with pready stalls and withdrawals
        pready_rand = 1;
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 3) == 0)
                        post(i, $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 65535));
                end else if ($urandom_range(0, 15) == 0) begin
                    pend[i] = 0;
                end
            end
            tick();
        end
        pready_rand = 0;
        pready = 1;
        for (int i = 0; i < NR; i++) pend[i] = 0;
        repeat (6) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
